// File: rtl/regfile_renamed_pkg.sv
// Shared constants for the renamed register file and its scoreboard.
package regfile_renamed_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREG  = 32;
    localparam int DEF_TAG_W = 4;

    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;

    localparam logic [DEF_XLEN-1:0]          ZeroWord    = '0;
    localparam logic [$clog2(DEF_NREG)-1:0]  ZeroRegAddr = '0;

endpackage

// File: rtl/regfile_renamed_scoreboard.sv
// Rename scoreboard: per-register busy bit and producer ROB tag, plus a
// running count of busy registers kept equal to the popcount of busy.
module regfile_scoreboard
    import regfile_renamed_pkg::*;
#(
    parameter int NREG  = DEF_NREG,
    parameter int TAG_W = DEF_TAG_W,
    parameter int AW    = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr,
    input  logic [TAG_W-1:0]      iss_tag,
    input  logic                  cm_en,
    input  logic [AW-1:0]         cm_addr,
    input  logic [TAG_W-1:0]      cm_tag,
    input  logic                  flush,
    output logic [NREG-1:0]       busy,
    output logic [NREG*TAG_W-1:0] tags,
    output logic [AW:0]           busy_cnt
);

    logic             r_busy [NREG];
    logic [TAG_W-1:0] r_tag  [NREG];
    logic [AW:0]      r_busy_cnt;

    logic w_iss_live;
    logic w_cm_clr;
    logic w_inc;
    logic w_dec;

    assign w_iss_live = rdy && !flush && iss_en && (iss_addr != AW'(ZeroRegAddr));
    assign w_cm_clr   = rdy && !flush && cm_en && (cm_addr != AW'(ZeroRegAddr))
                        && r_busy[cm_addr] && (r_tag[cm_addr] == cm_tag);
    assign w_inc      = w_iss_live && !r_busy[iss_addr];
    // A clear overridden by a same-register issue leaves the register busy.
    assign w_dec      = w_cm_clr && !(w_iss_live && (iss_addr == cm_addr));

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_busy[gi] <= Disable;
                    r_tag[gi]  <= '0;
                end else if (rdy) begin
                    if (flush) begin
                        r_busy[gi] <= Disable;
                    end else if (w_iss_live && (iss_addr == AW'(gi))) begin
                        r_busy[gi] <= Enable;
                        r_tag[gi]  <= iss_tag;
                    end else if (w_cm_clr && (cm_addr == AW'(gi))) begin
                        r_busy[gi] <= Disable;
                    end
                end
            end
            assign busy[gi]                = r_busy[gi];
            assign tags[gi*TAG_W +: TAG_W] = r_tag[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy_cnt <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_busy_cnt <= '0;
            end else begin
                r_busy_cnt <= r_busy_cnt + (AW+1)'(w_inc) - (AW+1)'(w_dec);
            end
        end
    end

    assign busy_cnt = r_busy_cnt;

endmodule

// File: rtl/regfile_renamed.sv
// Architectural register file with NRD combinational read ports, commit
// forwarding and a rename scoreboard for outstanding producers.
module regfile_renamed
    import regfile_renamed_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREG  = DEF_NREG,
    parameter int NRD   = 2,
    parameter int TAG_W = DEF_TAG_W,
    parameter int AW    = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_val,
    output logic [NRD-1:0]        rd_busy,
    output logic [NRD*TAG_W-1:0]  rd_tag,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr,
    input  logic [TAG_W-1:0]      iss_tag,
    input  logic                  cm_en,
    input  logic [AW-1:0]         cm_addr,
    input  logic [TAG_W-1:0]      cm_tag,
    input  logic [XLEN-1:0]       cm_data,
    input  logic                  flush,
    output logic [AW:0]           busy_cnt
);

    logic [XLEN-1:0]       r_val [NREG];
    logic [NREG-1:0]       w_busy;
    logic [NREG*TAG_W-1:0] w_tags;
    logic                  w_cm_write;

    // Commits write their value even during a flush; only rdy gates them.
    assign w_cm_write = rdy && cm_en && (cm_addr != AW'(ZeroRegAddr));

    regfile_scoreboard #(
        .NREG  (NREG),
        .TAG_W (TAG_W),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .iss_tag  (iss_tag),
        .cm_en    (cm_en),
        .cm_addr  (cm_addr),
        .cm_tag   (cm_tag),
        .flush    (flush),
        .busy     (w_busy),
        .tags     (w_tags),
        .busy_cnt (busy_cnt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_val
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_val[gi] <= XLEN'(ZeroWord);
                end else if (w_cm_write && (cm_addr == AW'(gi))) begin
                    r_val[gi] <= cm_data;
                end
            end
        end

        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]    w_addr;
            logic             w_fwd;
            logic [TAG_W-1:0] w_tag;

            assign w_addr = rd_addr[gi*AW +: AW];
            assign w_fwd  = cm_en && (cm_addr == w_addr) && (w_addr != AW'(ZeroRegAddr));
            assign w_tag  = w_tags[int'(w_addr)*TAG_W +: TAG_W];

            // Register 0 never becomes busy and its tag stays 0, so only the value needs masking.
            assign rd_val[gi*XLEN +: XLEN] = (w_addr == AW'(ZeroRegAddr)) ? XLEN'(ZeroWord) :
                                             w_fwd ? cm_data : r_val[w_addr];
            assign rd_busy[gi]             = w_busy[w_addr] && !(w_fwd && (w_tag == cm_tag));
            assign rd_tag[gi*TAG_W +: TAG_W] = w_tag;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_renamed.sv
// Self-checking bench for regfile_renamed: directed scenarios plus random traffic vs. an array model.
module tb_regfile_renamed;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int NRD   = 2;
    localparam int TAG_W = 4;
    localparam int AW    = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 rdy;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_val;
    logic [NRD-1:0]       rd_busy;
    logic [NRD*TAG_W-1:0] rd_tag;
    logic                 iss_en;
    logic [AW-1:0]        iss_addr;
    logic [TAG_W-1:0]     iss_tag;
    logic                 cm_en;
    logic [AW-1:0]        cm_addr;
    logic [TAG_W-1:0]     cm_tag;
    logic [XLEN-1:0]      cm_data;
    logic                 flush;
    logic [AW:0]          busy_cnt;

    int checks   = 0;
    int failures = 0;

    logic [XLEN-1:0]  m_val  [NREG];
    logic             m_busy [NREG];
    logic [TAG_W-1:0] m_tag  [NREG];

    regfile_renamed #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .TAG_W(TAG_W), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .rd_addr(rd_addr), .rd_val(rd_val), .rd_busy(rd_busy), .rd_tag(rd_tag),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_tag(iss_tag),
        .cm_en(cm_en), .cm_addr(cm_addr), .cm_tag(cm_tag), .cm_data(cm_data),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    function automatic int model_cnt();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic logic [XLEN-1:0] exp_val(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (cm_en && cm_addr == a) return cm_data;
        return m_val[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (cm_en && cm_addr == a && m_tag[a] == cm_tag) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
        end
    endtask

    task automatic model_edge();
        if (rdy) begin
            if (cm_en && cm_addr != 0) begin
                m_val[cm_addr] = cm_data;
                if (!flush && m_busy[cm_addr] && m_tag[cm_addr] == cm_tag) m_busy[cm_addr] = 1'b0;
            end
            if (flush) begin
                for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
            end else if (iss_en && iss_addr != 0) begin
                m_busy[iss_addr] = 1'b1;
                m_tag[iss_addr]  = iss_tag;
            end
        end
    endtask

    task automatic idle();
        rdy = 1'b1; iss_en = 1'b0; cm_en = 1'b0; flush = 1'b0;
        iss_addr = '0; iss_tag = '0; cm_addr = '0; cm_tag = '0; cm_data = '0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        rd_addr[k*AW +: AW] = a;
    endtask

    task automatic issue(input logic [AW-1:0] a, input logic [TAG_W-1:0] t);
        iss_en = 1'b1; iss_addr = a; iss_tag = t;
    endtask

    task automatic commit(input logic [AW-1:0] a, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] d);
        cm_en = 1'b1; cm_addr = a; cm_tag = t; cm_data = d;
    endtask

    task automatic test_reset();
        idle(); rd_addr = '0; rst = 1'b0; model_reset();
        #12 rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy_cnt !== 0 || rd_val !== '0 || rd_busy !== '0) begin
            failures++; $display("FAIL reset_init: busy_cnt=%0d rd_val=%h rd_busy=%b, required 0/0/0", busy_cnt, rd_val, rd_busy);
        end
        set_rd(0, 5'd5);
        issue(5'd5, 4'd3);
        tick();
        idle();
        checks++;
        if (busy_cnt !== 1 || rd_busy[0] !== 1'b1) begin
            failures++; $display("FAIL reset_pre_issue: busy_cnt=%0d busy=%b, required 1/1", busy_cnt, rd_busy[0]);
        end
        #2 rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (rd_busy[0] !== 1'b0 || rd_val[0 +: XLEN] !== '0 || busy_cnt !== 0) begin
            failures++; $display("FAIL reset_async: busy=%b val=%h busy_cnt=%0d, required 0/0/0", rd_busy[0], rd_val[0 +: XLEN], busy_cnt);
        end
        #1 rst = 1'b1;
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_commit_forward();
        issue(5'd5, 4'd3); set_rd(0, 5'd5);
        tick();
        idle(); commit(5'd5, 4'd3, 32'hDEADBEEF);
        #1;
        checks++;
        if (rd_val[0 +: XLEN] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0) begin
            failures++; $display("FAIL fwd_same_cycle: val=%h busy=%b, required deadbeef/0", rd_val[0 +: XLEN], rd_busy[0]);
        end
        tick();
        idle(); #1;
        checks++;
        if (rd_val[0 +: XLEN] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0 || busy_cnt !== 0) begin
            failures++; $display("FAIL fwd_after: val=%h busy=%b cnt=%0d, required deadbeef/0/0", rd_val[0 +: XLEN], rd_busy[0], busy_cnt);
        end
        $display("test_commit_forward done");
    endtask

    task automatic test_stale_commit();
        issue(5'd7, 4'd2); tick();
        issue(5'd7, 4'd6); tick();
        idle(); commit(5'd7, 4'd2, 32'h11); set_rd(1, 5'd7);
        #1;
        checks++;
        if (rd_val[XLEN +: XLEN] !== 32'h11 || rd_busy[1] !== 1'b1 || rd_tag[TAG_W +: TAG_W] !== 4'd6) begin
            failures++; $display("FAIL stale_commit: val=%h busy=%b tag=%0d, required 11/1/6", rd_val[XLEN +: XLEN], rd_busy[1], rd_tag[TAG_W +: TAG_W]);
        end
        tick();
        idle(); #1;
        checks++;
        if (busy_cnt !== 1 || rd_busy[1] !== 1'b1 || rd_val[XLEN +: XLEN] !== 32'h11) begin
            failures++; $display("FAIL stale_after: cnt=%0d busy=%b val=%h, required 1/1/11", busy_cnt, rd_busy[1], rd_val[XLEN +: XLEN]);
        end
        $display("test_stale_commit done");
    endtask

    task automatic test_same_cycle_issue();
        commit(5'd9, 4'd0, 32'h55); tick();
        idle(); issue(5'd9, 4'd4); set_rd(0, 5'd9);
        #1;
        checks++;
        if (rd_val[0 +: XLEN] !== 32'h55 || rd_busy[0] !== 1'b0) begin
            failures++; $display("FAIL issue_hidden: val=%h busy=%b, required 55/0", rd_val[0 +: XLEN], rd_busy[0]);
        end
        tick();
        idle(); #1;
        checks++;
        if (rd_busy[0] !== 1'b1 || rd_tag[0 +: TAG_W] !== 4'd4 || busy_cnt !== 2) begin
            failures++; $display("FAIL issue_visible: busy=%b tag=%0d cnt=%0d, required 1/4/2", rd_busy[0], rd_tag[0 +: TAG_W], busy_cnt);
        end
        $display("test_same_cycle_issue done");
    endtask

    task automatic test_flush();
        logic [AW-1:0] probe [5];
        probe = '{5'd3, 5'd4, 5'd7, 5'd9, 5'd10};
        issue(5'd10, 4'd1); tick();
        idle(); #1;
        checks++;
        if (busy_cnt !== 3) begin
            failures++; $display("FAIL flush_pre: cnt=%0d, required 3", busy_cnt);
        end
        flush = 1'b1; commit(5'd3, 4'd0, 32'h77); issue(5'd4, 4'd5);
        tick();
        idle();
        for (int i = 0; i < 5; i++) begin
            set_rd(0, probe[i]); #1;
            checks++;
            if (rd_busy[0] !== 1'b0) begin
                failures++; $display("FAIL flush_busy x%0d: busy=%b, required 0", probe[i], rd_busy[0]);
            end
        end
        set_rd(1, 5'd3); #1;
        checks++;
        if (rd_val[XLEN +: XLEN] !== 32'h77 || busy_cnt !== 0) begin
            failures++; $display("FAIL flush_commit: x3=%h cnt=%0d, required 77/0", rd_val[XLEN +: XLEN], busy_cnt);
        end
        @(posedge clk); #1;
        $display("test_flush done");
    endtask

    task automatic test_x0_rdy();
        issue(5'd0, 4'd7); commit(5'd0, 4'd0, 32'hFFFFFFFF); set_rd(0, 5'd0);
        #1;
        checks++;
        if (rd_val[0 +: XLEN] !== '0 || rd_busy[0] !== 1'b0 || rd_tag[0 +: TAG_W] !== '0) begin
            failures++; $display("FAIL x0_during: val=%h busy=%b tag=%0d, required 0/0/0", rd_val[0 +: XLEN], rd_busy[0], rd_tag[0 +: TAG_W]);
        end
        tick();
        idle(); #1;
        checks++;
        if (rd_val[0 +: XLEN] !== '0 || rd_busy[0] !== 1'b0 || busy_cnt !== 0) begin
            failures++; $display("FAIL x0_after: val=%h busy=%b cnt=%0d, required 0/0/0", rd_val[0 +: XLEN], rd_busy[0], busy_cnt);
        end
        commit(5'd8, 4'd0, 32'hABCD); tick();
        idle(); rdy = 1'b0; commit(5'd8, 4'd0, 32'h1); issue(5'd12, 4'd3);
        tick();
        idle(); set_rd(0, 5'd8); set_rd(1, 5'd12); #1;
        checks++;
        if (rd_val[0 +: XLEN] !== 32'hABCD || rd_busy[1] !== 1'b0 || busy_cnt !== 0) begin
            failures++; $display("FAIL rdy_hold: x8=%h x12busy=%b cnt=%0d, required abcd/0/0", rd_val[0 +: XLEN], rd_busy[1], busy_cnt);
        end
        $display("test_x0_rdy done");
    endtask

    task automatic test_random();
        int loc_fail = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [AW-1:0] a;
            idle();
            rdy   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 1) == 1) issue(AW'($urandom_range(0, 7)), TAG_W'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                a = AW'($urandom_range(0, 7));
                commit(a, ($urandom_range(0, 2) != 0) ? m_tag[a] : TAG_W'($urandom), $urandom);
            end
            for (int k = 0; k < NRD; k++) set_rd(k, AW'($urandom_range(0, 9)));
            #1;
            for (int k = 0; k < NRD; k++) begin
                a = rd_addr[k*AW +: AW];
                checks++;
                if (rd_val[k*XLEN +: XLEN] !== exp_val(a) || rd_busy[k] !== exp_busy(a) ||
                    (exp_busy(a) && rd_tag[k*TAG_W +: TAG_W] !== m_tag[a])) begin
                    failures++; loc_fail++;
                    $display("FAIL rand_read cyc%0d port%0d x%0d: val=%h busy=%b tag=%0d, required %h/%b/%0d",
                             cyc, k, a, rd_val[k*XLEN +: XLEN], rd_busy[k], rd_tag[k*TAG_W +: TAG_W],
                             exp_val(a), exp_busy(a), m_tag[a]);
                end
            end
            tick();
            checks++;
            if (int'(busy_cnt) != model_cnt()) begin
                failures++; loc_fail++;
                $display("FAIL rand_cnt cyc%0d: busy_cnt=%0d, required %0d", cyc, busy_cnt, model_cnt());
            end
        end
        idle();
        $display("test_random done: 400 cycles, %0d mismatched comparisons", loc_fail);
    endtask

    initial begin
        test_reset();
        test_commit_forward();
        test_stale_commit();
        test_same_cycle_issue();
        test_flush();
        test_x0_rdy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
